// File: rtl/mem_1r1w_sequencer.sv
// mem_1r1w_sequencer: presents a 1-read/1-write port pair on a single-port
// 1RW SRAM macro. Writes go into a small in-order buffer and are drained into
// free macro slots. Reads take priority unless the buffer is full, a buffered
// write targets the read address, or writes have been starved too long.
//
// Ports:
//   clock, reset          : sole clock; synchronous active-high reset
//   W0_valid/ready/addr/data/mask : write request channel (byte mask)
//   R0_valid/ready/addr   : read request channel (ready = issued this cycle)
//   R0_rvalid/rdata       : read response, one cycle after issue
//   mem_*                 : macro controls; mem_rd_out valid one cycle after read
//   wbuf_count            : write-buffer occupancy (debug)
module mem_1r1w_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WBUF_DEPTH = 2,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          W0_valid,
  output logic                          W0_ready,
  input  logic [ADDR_W-1:0]             W0_addr,
  input  logic [DATA_W-1:0]             W0_data,
  input  logic [DATA_W/8-1:0]           W0_mask,
  input  logic                          R0_valid,
  output logic                          R0_ready,
  input  logic [ADDR_W-1:0]             R0_addr,
  output logic                          R0_rvalid,
  output logic [DATA_W-1:0]             R0_rdata,
  output logic                          mem_ce_in,
  output logic                          mem_we_in,
  output logic [DATA_W-1:0]             mem_w_mask_in,
  output logic [ADDR_W-1:0]             mem_addr_in,
  output logic [DATA_W-1:0]             mem_wd_in,
  input  logic [DATA_W-1:0]             mem_rd_out,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STV_W  = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_WFORCE,
    SLOT_READ,
    SLOT_WDRAIN
  } slot_e;

  logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];
  logic [MASK_W-1:0] wb_mask [WBUF_DEPTH];

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [STV_W-1:0]      starve;
  logic                  rvalid_q;
  logic [WBUF_DEPTH-1:0] hit;
  logic                  hazard;
  logic                  full;
  logic                  pending;
  logic                  wforce;
  logic                  push;
  logic                  pop;
  slot_e                 slot;

  // Address match against occupied entries only (registered contents).
  for (genvar g = 0; g < WBUF_DEPTH; g++) begin : g_hit
    logic [PTR_W-1:0] ofs;
    assign ofs    = PTR_W'(g) - rd_ptr;
    assign hit[g] = ({1'b0, ofs} < count) && (wb_addr[g] == R0_addr);
  end

  assign hazard  = R0_valid && (|hit);
  assign full    = (count == CNT_W'(WBUF_DEPTH));
  assign pending = (count != '0);
  assign wforce  = full || hazard || ((starve == STV_W'(STARVE_LIM)) && pending);

  assign W0_ready   = !reset && !full;
  assign push       = W0_valid && W0_ready;
  assign wbuf_count = reset ? '0 : count;
  // Gating with reset suppresses the response of a read issued just before reset.
  assign R0_rvalid  = rvalid_q && !reset;
  assign R0_rdata   = mem_rd_out;

  // Slot arbitration: one macro access per cycle.
  always_comb begin
    slot = SLOT_IDLE;
    if (!reset) begin
      if (wforce)        slot = SLOT_WFORCE;
      else if (R0_valid) slot = SLOT_READ;
      else if (pending)  slot = SLOT_WDRAIN;
    end
  end

  // Macro drive for the selected slot.
  always_comb begin
    mem_ce_in     = 1'b0;
    mem_we_in     = 1'b0;
    mem_addr_in   = '0;
    mem_wd_in     = '0;
    mem_w_mask_in = '0;
    R0_ready      = 1'b0;
    pop           = 1'b0;
    unique case (slot)
      SLOT_WFORCE, SLOT_WDRAIN: begin
        mem_ce_in   = 1'b1;
        mem_we_in   = 1'b1;
        mem_addr_in = wb_addr[rd_ptr];
        mem_wd_in   = wb_data[rd_ptr];
        for (int unsigned b = 0; b < MASK_W; b++) begin
          mem_w_mask_in[8*b +: 8] = {8{wb_mask[rd_ptr][b]}};
        end
        pop = 1'b1;
      end
      SLOT_READ: begin
        mem_ce_in   = 1'b1;
        mem_addr_in = R0_addr;
        R0_ready    = 1'b1;
      end
      default: ;
    endcase
  end

  // Control state: pointers, occupancy, starvation counter, response flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      starve   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop || !pending) begin
        starve <= '0;
      end else if ((slot == SLOT_READ) && (starve != STV_W'(STARVE_LIM))) begin
        starve <= starve + STV_W'(1);
      end
      rvalid_q <= (slot == SLOT_READ);
    end
  end

  // Buffer storage; contents of empty slots are don't-care.
  always_ff @(posedge clock) begin
    if (push) begin
      wb_addr[wr_ptr] <= W0_addr;
      wb_data[wr_ptr] <= W0_data;
      wb_mask[wr_ptr] <= W0_mask;
    end
  end

endmodule

// File: tb/tb_mem_1r1w_sequencer.sv
module tb_mem_1r1w_sequencer;

  logic        clock;
  logic        reset;
  logic        W0_valid;
  logic        W0_ready;
  logic [9:0]  W0_addr;
  logic [31:0] W0_data;
  logic [3:0]  W0_mask;
  logic        R0_valid;
  logic        R0_ready;
  logic [9:0]  R0_addr;
  logic        R0_rvalid;
  logic [31:0] R0_rdata;
  logic        mem_ce_in;
  logic        mem_we_in;
  logic [31:0] mem_w_mask_in;
  logic [9:0]  mem_addr_in;
  logic [31:0] mem_wd_in;
  logic [31:0] mem_rd_out;
  logic [1:0]  wbuf_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_t;

  wr_t         pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] commit_mem [1024] = '{default: '0};
  logic [31:0] ram        [1024] = '{default: '0};
  logic [31:0] rd_q = '0;

  mem_1r1w_sequencer dut (
    .clock(clock), .reset(reset),
    .W0_valid(W0_valid), .W0_ready(W0_ready), .W0_addr(W0_addr),
    .W0_data(W0_data), .W0_mask(W0_mask),
    .R0_valid(R0_valid), .R0_ready(R0_ready), .R0_addr(R0_addr),
    .R0_rvalid(R0_rvalid), .R0_rdata(R0_rdata),
    .mem_ce_in(mem_ce_in), .mem_we_in(mem_we_in), .mem_w_mask_in(mem_w_mask_in),
    .mem_addr_in(mem_addr_in), .mem_wd_in(mem_wd_in), .mem_rd_out(mem_rd_out),
    .wbuf_count(wbuf_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural single-port macro: bit-masked write, 1-cycle read latency.
  always @(posedge clock) begin
    if (mem_ce_in) begin
      if (mem_we_in) ram[mem_addr_in] <= (ram[mem_addr_in] & ~mem_w_mask_in) | (mem_wd_in & mem_w_mask_in);
      else           rd_q <= ram[mem_addr_in];
    end
  end
  assign mem_rd_out = rd_q;

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] e;
    for (int i = 0; i < 4; i++) e[8*i +: 8] = {8{m[i]}};
    return e;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input wr_t w);
    logic [31:0] e;
    e = expand(w.mask);
    return (old & ~e) | (w.data & e);
  endfunction

  // Architectural view: committed memory plus all accepted-but-pending writes.
  function automatic logic [31:0] view(input logic [9:0] a);
    logic [31:0] v;
    v = commit_mem[a];
    foreach (pend_q[i]) if (pend_q[i].addr == a) v = merge(v, pend_q[i]);
    return v;
  endfunction

  // Scoreboard: record handshakes, compare responses and macro writes in order.
  always @(negedge clock) begin
    if (reset) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (R0_rvalid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_rvalid_unexpected: got rvalid=1 rdata=%h, want no response", R0_rdata);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (R0_rdata !== e) begin
            errors++;
            $display("FAIL sb_rdata: got %h want %h", R0_rdata, e);
          end
        end
      end
      if (mem_ce_in && mem_we_in) begin
        checks++;
        if (pend_q.size() == 0) begin
          errors++;
          $display("FAIL sb_write_unexpected: got write addr=%h data=%h, want none", mem_addr_in, mem_wd_in);
        end else begin
          wr_t w;
          w = pend_q.pop_front();
          if (mem_addr_in !== w.addr || mem_wd_in !== w.data || mem_w_mask_in !== expand(w.mask)) begin
            errors++;
            $display("FAIL sb_write: got addr=%h data=%h mask=%h want addr=%h data=%h mask=%h",
                     mem_addr_in, mem_wd_in, mem_w_mask_in, w.addr, w.data, expand(w.mask));
          end
          commit_mem[w.addr] = merge(commit_mem[w.addr], w);
        end
      end
      if (R0_valid && R0_ready) exp_q.push_back(view(R0_addr));
      if (W0_valid && W0_ready) pend_q.push_back('{addr: W0_addr, data: W0_data, mask: W0_mask});
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    W0_valid = 1'b0;
    R0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    idle();
    cyc();
    while (wbuf_count != 2'd0 && n < 40) begin
      cyc();
      n++;
    end
    checks++;
    if (wbuf_count !== 2'd0) begin errors++; $display("FAIL drain_timeout: got count=%0d want 0", wbuf_count); end
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    W0_valid = 1'b1; W0_addr = 10'h001; W0_data = 32'h1; W0_mask = 4'hF;
    R0_valid = 1'b1; R0_addr = 10'h001;
    cyc();
    cyc();
    @(negedge clock);
    checks++;
    if (W0_ready !== 1'b0 || R0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got w=%b r=%b want 0 0", W0_ready, R0_ready); end
    checks++;
    if (mem_ce_in !== 1'b0 || mem_we_in !== 1'b0 || mem_addr_in !== 10'h0 || mem_wd_in !== 32'h0 || mem_w_mask_in !== 32'h0)
      begin errors++; $display("FAIL reset_mem: got ce=%b we=%b addr=%h want all 0", mem_ce_in, mem_we_in, mem_addr_in); end
    checks++;
    if (wbuf_count !== 2'd0 || R0_rvalid !== 1'b0) begin errors++; $display("FAIL reset_count: got count=%0d rvalid=%b want 0 0", wbuf_count, R0_rvalid); end
    cyc();
    reset = 1'b0;
    idle();
    @(negedge clock);
    checks++;
    if (W0_ready !== 1'b1 || mem_ce_in !== 1'b0 || wbuf_count !== 2'd0)
      begin errors++; $display("FAIL reset_release: got wready=%b ce=%b count=%0d want 1 0 0", W0_ready, mem_ce_in, wbuf_count); end
  endtask

  task automatic test_basic();
    cyc();
    W0_valid = 1'b1; W0_addr = 10'h005; W0_data = 32'hDEADBEEF; W0_mask = 4'hF;
    @(negedge clock);
    checks++;
    if (W0_ready !== 1'b1 || mem_ce_in !== 1'b0) begin errors++; $display("FAIL basic_accept: got wready=%b ce=%b want 1 0", W0_ready, mem_ce_in); end
    cyc();
    idle();
    @(negedge clock);
    checks++;
    if (mem_ce_in !== 1'b1 || mem_we_in !== 1'b1 || mem_addr_in !== 10'h005 || mem_wd_in !== 32'hDEADBEEF || mem_w_mask_in !== 32'hFFFFFFFF)
      begin errors++; $display("FAIL basic_write: got ce=%b we=%b addr=%h wd=%h m=%h", mem_ce_in, mem_we_in, mem_addr_in, mem_wd_in, mem_w_mask_in); end
    checks++;
    if (wbuf_count !== 2'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", wbuf_count); end
    cyc();
    R0_valid = 1'b1; R0_addr = 10'h005;
    @(negedge clock);
    checks++;
    if (R0_ready !== 1'b1 || mem_we_in !== 1'b0 || mem_addr_in !== 10'h005 || mem_wd_in !== 32'h0 || mem_w_mask_in !== 32'h0)
      begin errors++; $display("FAIL basic_read: got ready=%b we=%b addr=%h wd=%h m=%h", R0_ready, mem_we_in, mem_addr_in, mem_wd_in, mem_w_mask_in); end
    cyc();
    idle();
    @(negedge clock);
    checks++;
    if (R0_rvalid !== 1'b1 || R0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata: got v=%b d=%h want 1 DEADBEEF", R0_rvalid, R0_rdata); end
  endtask

  task automatic test_mask();
    cyc();
    W0_valid = 1'b1; W0_addr = 10'h010; W0_data = 32'h11223344; W0_mask = 4'hF;
    cyc();
    idle();
    cyc();
    W0_valid = 1'b1; W0_addr = 10'h010; W0_data = 32'hAABBCCDD; W0_mask = 4'b0101;
    cyc();
    idle();
    @(negedge clock);
    checks++;
    if (mem_we_in !== 1'b1 || mem_w_mask_in !== 32'h00FF00FF) begin errors++; $display("FAIL mask_bits: got we=%b m=%h want 1 00FF00FF", mem_we_in, mem_w_mask_in); end
    cyc();
    R0_valid = 1'b1; R0_addr = 10'h010;
    cyc();
    idle();
    @(negedge clock);
    checks++;
    if (R0_rvalid !== 1'b1 || R0_rdata !== 32'h11BB33DD) begin errors++; $display("FAIL mask_rdata: got v=%b d=%h want 1 11BB33DD", R0_rvalid, R0_rdata); end
  endtask

  task automatic test_hazard();
    cyc();
    W0_valid = 1'b1; W0_addr = 10'h020; W0_data = 32'h12345678; W0_mask = 4'hF;
    cyc();
    W0_valid = 1'b0;
    R0_valid = 1'b1; R0_addr = 10'h020;
    @(negedge clock);
    checks++;
    if (R0_ready !== 1'b0 || mem_we_in !== 1'b1 || mem_addr_in !== 10'h020) begin errors++; $display("FAIL hazard_force: got ready=%b we=%b addr=%h want 0 1 020", R0_ready, mem_we_in, mem_addr_in); end
    cyc();
    @(negedge clock);
    checks++;
    if (R0_ready !== 1'b1) begin errors++; $display("FAIL hazard_retry: got ready=%b want 1", R0_ready); end
    cyc();
    idle();
    @(negedge clock);
    checks++;
    if (R0_rvalid !== 1'b1 || R0_rdata !== 32'h12345678) begin errors++; $display("FAIL hazard_new: got v=%b d=%h want 1 12345678", R0_rvalid, R0_rdata); end
    // Same-cycle write and read to one address: the read sees old data.
    cyc();
    W0_valid = 1'b1; W0_addr = 10'h030; W0_data = 32'h0BADF00D; W0_mask = 4'hF;
    cyc();
    idle();
    cyc();
    W0_valid = 1'b1; W0_addr = 10'h030; W0_data = 32'hCAFE0001; W0_mask = 4'hF;
    R0_valid = 1'b1; R0_addr = 10'h030;
    @(negedge clock);
    checks++;
    if (R0_ready !== 1'b1 || W0_ready !== 1'b1) begin errors++; $display("FAIL same_cycle_ready: got r=%b w=%b want 1 1", R0_ready, W0_ready); end
    cyc();
    idle();
    @(negedge clock);
    checks++;
    if (R0_rvalid !== 1'b1 || R0_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL same_cycle_old: got v=%b d=%h want 1 0BADF00D", R0_rvalid, R0_rdata); end
    checks++;
    if (mem_we_in !== 1'b1 || mem_wd_in !== 32'hCAFE0001) begin errors++; $display("FAIL same_cycle_drain: got we=%b wd=%h want 1 CAFE0001", mem_we_in, mem_wd_in); end
    cyc();
    R0_valid = 1'b1; R0_addr = 10'h030;
    cyc();
    idle();
    @(negedge clock);
    checks++;
    if (R0_rvalid !== 1'b1 || R0_rdata !== 32'hCAFE0001) begin errors++; $display("FAIL same_cycle_new: got v=%b d=%h want 1 CAFE0001", R0_rvalid, R0_rdata); end
  endtask

  task automatic test_full();
    int widx;
    widx = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      R0_valid = 1'b1; R0_addr = 10'h100;
      W0_valid = (widx < 3);
      W0_addr = 10'h200 + 10'(widx); W0_data = 32'hF0000000 + 32'(widx); W0_mask = 4'hF;
      @(negedge clock);
      if (c == 2) begin
        checks++;
        if (W0_ready !== 1'b0 || widx != 2) begin errors++; $display("FAIL full_wready: got wready=%b accepts=%0d want 0 2", W0_ready, widx); end
        checks++;
        if (R0_ready !== 1'b0 || mem_we_in !== 1'b1 || mem_addr_in !== 10'h200)
          begin errors++; $display("FAIL full_force: got ready=%b we=%b addr=%h want 0 1 200", R0_ready, mem_we_in, mem_addr_in); end
      end
      if (W0_valid && W0_ready) widx++;
    end
    checks++;
    if (widx != 3) begin errors++; $display("FAIL full_accepts: got %0d want 3", widx); end
    wait_drain();
  endtask

  task automatic test_starve();
    cyc();
    W0_valid = 1'b1; W0_addr = 10'h300; W0_data = 32'h5A5A0000; W0_mask = 4'hF;
    R0_valid = 1'b1; R0_addr = 10'h101;
    @(negedge clock);
    checks++;
    if (W0_ready !== 1'b1 || R0_ready !== 1'b1) begin errors++; $display("FAIL starve_start: got w=%b r=%b want 1 1", W0_ready, R0_ready); end
    for (int c = 1; c <= 8; c++) begin
      cyc();
      W0_valid = 1'b0;
      R0_addr = 10'h101 + 10'(c);
      @(negedge clock);
      checks++;
      if (R0_ready !== 1'b1 || mem_we_in !== 1'b0) begin errors++; $display("FAIL starve_read%0d: got ready=%b we=%b want 1 0", c, R0_ready, mem_we_in); end
    end
    cyc();
    @(negedge clock);
    checks++;
    if (R0_ready !== 1'b0 || mem_we_in !== 1'b1 || mem_addr_in !== 10'h300)
      begin errors++; $display("FAIL starve_force: got ready=%b we=%b addr=%h want 0 1 300", R0_ready, mem_we_in, mem_addr_in); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    cyc();
    W0_valid = 1'b1; W0_addr = 10'h3A0; W0_data = 32'h77777777; W0_mask = 4'hF;
    cyc();
    W0_addr = 10'h3A1; W0_data = 32'h88888888;
    R0_valid = 1'b1; R0_addr = 10'h102;
    @(negedge clock);
    checks++;
    if (R0_ready !== 1'b1 || mem_we_in !== 1'b0) begin errors++; $display("FAIL rstmid_setup: got ready=%b we=%b want 1 0", R0_ready, mem_we_in); end
    cyc();
    idle();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (R0_rvalid !== 1'b0 || mem_ce_in !== 1'b0 || wbuf_count !== 2'd0 || W0_ready !== 1'b0)
      begin errors++; $display("FAIL rstmid_during: got rvalid=%b ce=%b count=%0d wready=%b want 0 0 0 0", R0_rvalid, mem_ce_in, wbuf_count, W0_ready); end
    cyc();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (W0_ready !== 1'b1 || wbuf_count !== 2'd0 || mem_ce_in !== 1'b0 || R0_rvalid !== 1'b0)
      begin errors++; $display("FAIL rstmid_release: got wready=%b count=%0d ce=%b rvalid=%b want 1 0 0 0", W0_ready, wbuf_count, mem_ce_in, R0_rvalid); end
    cyc();
    R0_valid = 1'b1; R0_addr = 10'h3A0;
    @(negedge clock);
    checks++;
    if (R0_ready !== 1'b1) begin errors++; $display("FAIL rstmid_read: got ready=%b want 1", R0_ready); end
    cyc();
    idle();
    @(negedge clock);
    checks++;
    if (R0_rvalid !== 1'b1 || R0_rdata !== 32'h0) begin errors++; $display("FAIL rstmid_discard: got v=%b d=%h want 1 00000000", R0_rvalid, R0_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] addrs [4];
    addrs = '{10'h005, 10'h010, 10'h020, 10'h030};
    for (int i = 0; i < 4; i++) begin
      cyc();
      R0_valid = 1'b1; R0_addr = addrs[i];
      @(negedge clock);
      checks++;
      if (R0_ready !== 1'b1 || mem_addr_in !== addrs[i]) begin errors++; $display("FAIL b2b_read%0d: got ready=%b addr=%h want 1 %h", i, R0_ready, mem_addr_in, addrs[i]); end
      if (i > 0) begin
        checks++;
        if (R0_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid%0d: got %b want 1", i, R0_rvalid); end
      end
    end
    cyc();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      cyc();
      R0_valid = 1'($urandom_range(0, 1));
      R0_addr  = 10'h040 + 10'($urandom_range(0, 3));
      W0_valid = 1'($urandom_range(0, 1));
      W0_addr  = 10'h040 + 10'($urandom_range(0, 3));
      W0_data  = $urandom;
      W0_mask  = 4'($urandom_range(0, 15));
    end
    wait_drain();
    checks++;
    if (pend_q.size() != 0 || exp_q.size() != 0)
      begin errors++; $display("FAIL random_leftover: got pending=%0d responses=%0d want 0 0", pend_q.size(), exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    W0_addr = '0; W0_data = '0; W0_mask = '0; R0_addr = '0;
    test_reset();
    test_basic();
    test_mask();
    test_hazard();
    test_full();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
